vector_lane_mem_responder: RTL and testbench

- Memory-side responder for the vector address scheduler's single serialized data port.
- Accepts one read or write per transaction (address, store data, size code).
- Performs the access against an internal word-organised SRAM after a fixed, parameterised latency, then returns a one-cycle hit with load data, or an exception.
- Serves as the data-cache stand-in for vector load/store unit integration and as the reference responder for scheduler verification.

---
 rtl/vector_lane_mem_responder.sv | 148 ++++++++++++++
 tb/tb_vector_lane_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_mem_responder.sv
// Fixed-latency memory responder: one outstanding byte/half/word access against a
// word-organised SRAM, answered with a single dhit or exception pulse.
module vector_lane_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  byte_ena,
    output logic        dhit,
    output logic [31:0] rdata,
    output logic        exception,
    output logic        busy
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rd_q, rd_d;
    logic        conflict_q, conflict_d;

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: every state flop uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            rd_q       <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            rd_q       <= rd_d;
            conflict_q <= conflict_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rd_d       = rd_q;
        conflict_d = conflict_q;
        case (state_q)
            IDLE: begin
                if (ren || wen) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    size_d     = byte_ena;
                    rd_d       = ren;
                    conflict_d = ren && wen;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request decode; an address below BASE_ADDR wraps to a huge 33-bit offset and faults.
    logic [32:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             legal;
    logic [3:0]       lane_en;
    logic [31:0]      wr_lanes;
    logic [31:0]      rd_shift;
    logic [31:0]      rd_mask;
    logic             resp;
    logic             we;

    always_comb begin
        offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        idx      = offset[IDX_W+1:2];
        lane     = addr_q[1:0];
        legal    = !conflict_q
                   && (size_q != 2'b11)
                   && !((size_q == 2'b01) && addr_q[0])
                   && !((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                   && (offset < SPAN);
        case (size_q)
            2'b00:   lane_en = 4'b0001 << lane;
            2'b01:   lane_en = 4'b0011 << lane;
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        case (size_q)
            2'b00:   rd_mask = 32'h0000_00FF;
            2'b01:   rd_mask = 32'h0000_FFFF;
            default: rd_mask = 32'hFFFF_FFFF;
        endcase
        wr_lanes = wdata_q << {lane, 3'b000};
        rd_shift = mem[idx] >> {lane, 3'b000};
        resp     = (state_q == RESP);
        we       = resp && legal && !rd_q;
    end

    // NOTE: the SRAM array has no reset; only control state is cleared by RST.
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign dhit      = resp && legal;
    assign exception = resp && !legal;
    assign busy      = (state_q != IDLE);
    assign rdata     = (dhit && rd_q) ? (rd_shift & rd_mask) : 32'h0;

endmodule

// File: tb/tb_vector_lane_mem_responder.sv
// Bench for vector_lane_mem_responder: three differently parameterised instances checked
// every cycle against a byte-array model, plus directed literal expectations.
module tb_vector_lane_mem_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ren       [3];
    logic        wen       [3];
    logic [31:0] addr      [3];
    logic [31:0] wdata     [3];
    logic [1:0]  byte_ena  [3];
    logic        dhit      [3];
    logic        exception [3];
    logic        busy      [3];
    logic [31:0] rdata     [3];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    vector_lane_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .CLK(CLK), .RST(RST), .ren(ren[0]), .wen(wen[0]), .addr(addr[0]), .wdata(wdata[0]),
        .byte_ena(byte_ena[0]), .dhit(dhit[0]), .rdata(rdata[0]), .exception(exception[0]), .busy(busy[0]));
    vector_lane_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) dut_b (
        .CLK(CLK), .RST(RST), .ren(ren[1]), .wen(wen[1]), .addr(addr[1]), .wdata(wdata[1]),
        .byte_ena(byte_ena[1]), .dhit(dhit[1]), .rdata(rdata[1]), .exception(exception[1]), .busy(busy[1]));
    vector_lane_mem_responder #(.DEPTH_WORDS(64), .LATENCY(4), .BASE_ADDR(32'h8000_0100)) dut_c (
        .CLK(CLK), .RST(RST), .ren(ren[2]), .wen(wen[2]), .addr(addr[2]), .wdata(wdata[2]),
        .byte_ena(byte_ena[2]), .dhit(dhit[2]), .rdata(rdata[2]), .exception(exception[2]), .busy(busy[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int k);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_1000;
            default: return 32'h8000_0100;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        return (k == 2) ? 64 : 256;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    endtask

    // ---------------- behavioural model: byte-addressed store + one pending response ----------------
    logic [7:0]  mdl [3][1024];
    bit          pend      [3];
    int          due_c     [3];
    bit          exp_ok    [3];
    bit          exp_rd    [3];
    logic [31:0] exp_rdata [3];
    logic [31:0] pa        [3];
    logic [31:0] pd        [3];
    logic [1:0]  psz       [3];

    function automatic bit model_legal(input int k, input bit r, input bit w, input logic [31:0] a,
                                       input logic [1:0] sz);
        longint off;
        off = longint'(a) - longint'(base_of(k));
        if (r && w) return 1'b0;
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd1 && a[0]) return 1'b0;
        if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b0;
        if (off < 0 || off >= longint'(depth_of(k)) * 4) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        int          off;
        v   = 32'h0;
        off = int'(a - base_of(k));
        for (int i = 0; i < (1 << sz); i++) v = v | (32'(mdl[k][off+i]) << (8 * i));
        return v;
    endfunction

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            logic        e_dhit, e_exc, e_busy;
            logic [31:0] e_rdata;
            bit          done;
            e_dhit = 1'b0; e_exc = 1'b0; e_busy = 1'b0; e_rdata = 32'h0; done = 1'b0;
            if (RST) begin
                pend[k] = 1'b0;
            end else if (pend[k] && cyc == due_c[k]) begin
                e_dhit  = exp_ok[k];
                e_exc   = !exp_ok[k];
                e_busy  = 1'b1;
                e_rdata = exp_rdata[k];
                done    = 1'b1;
            end else if (pend[k]) begin
                e_busy = 1'b1;
            end else if (ren[k] || wen[k]) begin
                pend[k]      = 1'b1;
                due_c[k]     = cyc + lat_of(k);
                pa[k]        = addr[k];
                pd[k]        = wdata[k];
                psz[k]       = byte_ena[k];
                exp_rd[k]    = ren[k];
                exp_ok[k]    = model_legal(k, ren[k], wen[k], addr[k], byte_ena[k]);
                exp_rdata[k] = (exp_ok[k] && ren[k]) ? model_read(k, addr[k], byte_ena[k]) : 32'h0;
            end
            check("dhit", k, 32'(dhit[k]), 32'(e_dhit));
            check("exception", k, 32'(exception[k]), 32'(e_exc));
            check("busy", k, 32'(busy[k]), 32'(e_busy));
            check("rdata", k, rdata[k], e_rdata);
            if (done) begin
                if (exp_ok[k] && !exp_rd[k]) begin
                    for (int i = 0; i < (1 << psz[k]); i++)
                        mdl[k][int'(pa[k] - base_of(k)) + i] = pd[k][8*i +: 8];
                end
                pend[k] = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic xact(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit hold, output bit hit, output bit exc,
                        output logic [31:0] rd, output int start_c, output int resp_c);
        @(posedge CLK);
        #1;
        ren[k] = r; wen[k] = w; addr[k] = a; wdata[k] = d; byte_ena[k] = sz;
        start_c = cyc;
        hit = 1'b0; exc = 1'b0; rd = 32'h0; resp_c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (dhit[k] || exception[k]) begin
                hit = dhit[k]; exc = exception[k]; rd = rdata[k]; resp_c = cyc;
                break;
            end
        end
        if (resp_c < 0) check("resp_timeout", k, 32'd0, 32'd1);
        if (!hold) begin
            @(posedge CLK);
            #1;
            ren[k] = 1'b0; wen[k] = 1'b0;
        end
    endtask

    task automatic run(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit exp_hit, input logic [31:0] exp_rd, input string name);
        bit          hit, exc;
        logic [31:0] rd;
        int          s, e;
        xact(k, r, w, a, d, sz, 1'b0, hit, exc, rd, s, e);
        check({name, "_hit"}, k, 32'(hit), 32'(exp_hit));
        check({name, "_exc"}, k, 32'(exc), 32'(!exp_hit));
        check({name, "_rdata"}, k, rd, exp_rd);
        check({name, "_latency"}, k, 32'(e - s), 32'(lat_of(k)));
    endtask

    initial begin
        bit          hit, exc;
        logic [31:0] rd1, rd2;
        int          s1, e1, s2, e2;

        for (int k = 0; k < 3; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; wdata[k] = '0; byte_ena[k] = '0;
        end
        RST = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_dhit", k, 32'(dhit[k]), 32'd0);
            check("rst_exception", k, 32'(exception[k]), 32'd0);
            check("rst_busy", k, 32'(busy[k]), 32'd0);
            check("rst_rdata", k, rdata[k], 32'd0);
        end
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;

        // word round trip, sub-word merge
        run(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1, 32'h0, "word_wr");
        run(0, 1, 0, 32'h10, 32'h0, 2'd2, 1, 32'hDEAD_BEEF, "word_rd");
        run(0, 0, 1, 32'h10, 32'h0, 2'd2, 1, 32'h0, "zero_wr");
        run(0, 0, 1, 32'h11, 32'hAA, 2'd0, 1, 32'h0, "byte_wr");
        run(0, 0, 1, 32'h12, 32'h1234, 2'd1, 1, 32'h0, "half_wr");
        run(0, 1, 0, 32'h10, 32'h0, 2'd2, 1, 32'h1234_AA00, "merge_rd");
        run(0, 1, 0, 32'h13, 32'h0, 2'd0, 1, 32'h0000_0012, "byte_rd");

        // misalignment, reserved size, conflict
        run(0, 0, 1, 32'h20, 32'hCAFE_F00D, 2'd2, 1, 32'h0, "w20_wr");
        run(0, 1, 0, 32'h21, 32'h0, 2'd1, 0, 32'h0, "half_misalign");
        run(0, 0, 1, 32'h22, 32'h1111_1111, 2'd2, 0, 32'h0, "word_misalign");
        run(0, 1, 0, 32'h20, 32'h0, 2'd2, 1, 32'hCAFE_F00D, "w20_intact");
        run(0, 1, 0, 32'h20, 32'h0, 2'd3, 0, 32'h0, "reserved_size");
        run(0, 1, 1, 32'h20, 32'h0, 2'd2, 0, 32'h0, "ren_wen_conflict");

        // range edges on the BASE_ADDR=0x1000 instance (LATENCY=1)
        run(1, 0, 1, 32'h13FC, 32'hA5A5_5A5A, 2'd2, 1, 32'h0, "top_wr");
        run(1, 1, 0, 32'h13FC, 32'h0, 2'd2, 1, 32'hA5A5_5A5A, "top_rd");
        run(1, 1, 0, 32'h1400, 32'h0, 2'd2, 0, 32'h0, "above_range");
        run(1, 1, 0, 32'h0FFC, 32'h0, 2'd2, 0, 32'h0, "below_range");
        run(2, 0, 1, 32'h8000_0100, 32'h0BAD_CAFE, 2'd2, 1, 32'h0, "c_base_wr");
        run(2, 1, 0, 32'h8000_0102, 32'h0, 2'd1, 1, 32'h0000_0BAD, "c_half_rd");
        run(2, 1, 0, 32'h8000_0200, 32'h0, 2'd0, 0, 32'h0, "c_above_range");

        // back-to-back with ren held: second response LATENCY+1 cycles after the first
        xact(0, 1, 0, 32'h10, 32'h0, 2'd2, 1'b1, hit, exc, rd1, s1, e1);
        xact(0, 1, 0, 32'h20, 32'h0, 2'd2, 1'b0, hit, exc, rd2, s2, e2);
        check("b2b_first_rdata", 0, rd1, 32'h1234_AA00);
        check("b2b_second_rdata", 0, rd2, 32'hCAFE_F00D);
        check("b2b_spacing", 0, 32'(e2 - e1), 32'd3);

        // reset during WAIT aborts the write
        run(0, 0, 1, 32'h40, 32'h1122_3344, 2'd2, 1, 32'h0, "w40_wr");
        @(posedge CLK);
        #1;
        wen[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h5555_5555; byte_ena[0] = 2'd2;
        @(posedge CLK);
        #1;
        check("busy_in_wait", 0, 32'(busy[0]), 32'd1);
        RST = 1'b1;
        #1;
        check("busy_after_rst", 0, 32'(busy[0]), 32'd0);
        check("dhit_after_rst", 0, 32'(dhit[0]), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        wen[0] = 1'b0;
        #1 RST = 1'b0;
        run(0, 1, 0, 32'h40, 32'h0, 2'd2, 1, 32'h1122_3344, "w40_after_rst");

        // preload every word so random reads hit known data
        for (int k = 0; k < 3; k++)
            for (int wd = 0; wd < depth_of(k); wd++)
                xact(k, 0, 1, base_of(k) + 32'(4 * wd), $urandom, 2'd2, 1'b0, hit, exc, rd1, s1, e1);

        // random traffic, checked cycle by cycle by the model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 150; i++) begin
                int          sel;
                bit          r, w, hold;
                logic [1:0]  sz;
                logic [31:0] a;
                sel  = $urandom_range(0, 9);
                sz   = 2'($urandom_range(0, 2));
                a    = base_of(k) + 32'(4 * $urandom_range(0, depth_of(k) - 1));
                if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
                if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
                r    = 1'($urandom_range(0, 1));
                w    = !r;
                if (sel == 0) a = $urandom;
                if (sel == 1) sz = 2'd3;
                if (sel == 2) begin r = 1'b1; w = 1'b1; end
                if (sel == 3) a = $urandom_range(0, 1) ? base_of(k) - 32'd4 : base_of(k) + 32'(4 * depth_of(k));
                hold = ($urandom_range(0, 3) == 0) && (i != 149);
                xact(k, r, w, a, $urandom, sz, hold, hit, exc, rd1, s1, e1);
            end
        end

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
